// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared constants, state encoding and sizing helper for popcount07 sequencers
package popcount_pkg;

    localparam int CHUNK = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int f_nchunk(input int width);
        return (width + CHUNK - 1) / CHUNK;
    endfunction

endpackage

// File: rtl/popcount07_chunk_mux.sv
// rtl/popcount07_chunk_mux.sv - selects one zero-padded 7-bit slice of x&w by chunk index
module popcount07_chunk_mux
    import popcount_pkg::*;
#(
    parameter int WIDTH  = 21,
    parameter int NCHUNK = f_nchunk(WIDTH),
    parameter int IW     = 1
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] w_i,
    input  logic [IW-1:0]    idx_i,
    output logic [CHUNK-1:0] chunk_o
);

    localparam int PW = NCHUNK * CHUNK;

    logic [PW-1:0] padded;

    always_comb begin
        padded             = '0;
        padded[WIDTH-1:0]  = x_i & w_i;
        chunk_o            = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            if (idx_i == IW'(c)) begin
                chunk_o = padded[c*CHUNK +: CHUNK];
            end
        end
    end

endmodule

// File: rtl/popcount07_tnn_seq.sv
// rtl/popcount07_tnn_seq.sv - time-multiplexes one external 7-input popcount core over a ternary neuron
module popcount07_tnn_seq
    import popcount_pkg::*;
#(
    parameter  int WIDTH  = 21,
    localparam int NCHUNK = f_nchunk(WIDTH),
    localparam int SW     = $clog2(NCHUNK * CHUNK + 1) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_wp,
    input  logic [WIDTH-1:0] in_wn,
    input  logic [SW-1:0]    thr,
    output logic [CHUNK-1:0] core_in,
    input  logic [2:0]       core_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    out_diff,
    output logic             out_fire
);

    localparam int            IW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] wp_q, wp_d;
    logic [WIDTH-1:0] wn_q, wn_d;
    logic [SW-1:0]    thr_q, thr_d;
    logic [SW-1:0]    pos_q, pos_d;
    logic [SW-1:0]    neg_q, neg_d;
    logic [SW-1:0]    diff_q, diff_d;
    logic             fire_q, fire_d;

    logic [WIDTH-1:0] w_sel;
    logic [CHUNK-1:0] chunk;
    logic [SW-1:0]    cnt_ext;
    logic [SW-1:0]    neg_sum;

    assign w_sel   = (state_q == NEG) ? wn_q : wp_q;
    assign cnt_ext = SW'(core_cnt);
    assign neg_sum = neg_q + cnt_ext;

    popcount07_chunk_mux #(
        .WIDTH  (WIDTH),
        .NCHUNK (NCHUNK),
        .IW     (IW)
    ) u_chunk_mux (
        .x_i     (x_q),
        .w_i     (w_sel),
        .idx_i   (idx_q),
        .chunk_o (chunk)
    );

    // Core input held at zero outside the counting phases so the core stays quiet.
    assign core_in   = ((state_q == POS) || (state_q == NEG)) ? chunk : '0;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_diff  = diff_q;
    assign out_fire  = fire_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        wp_d    = wp_q;
        wn_d    = wn_q;
        thr_d   = thr_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        diff_d  = diff_q;
        fire_d  = fire_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    wp_d    = in_wp;
                    wn_d    = in_wn;
                    thr_d   = thr;
                    pos_d   = '0;
                    neg_d   = '0;
                    idx_d   = '0;
                    state_d = POS;
                end
            end
            POS: begin
                pos_d = pos_q + cnt_ext;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = NEG;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            NEG: begin
                neg_d = neg_sum;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    diff_d  = pos_q - neg_sum;
                    fire_d  = ($signed(pos_q - neg_sum) >= $signed(thr_q));
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            wp_q    <= '0;
            wn_q    <= '0;
            thr_q   <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
            diff_q  <= '0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            wp_q    <= wp_d;
            wn_q    <= wn_d;
            thr_q   <= thr_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            diff_q  <= diff_d;
            fire_q  <= fire_d;
        end
    end

endmodule

// File: tb/tb_popcount07_tnn_seq.sv
// tb/tb_popcount07_tnn_seq.sv - directed scoreboard bench for popcount07_tnn_seq with exact and approximate cores
module tb_popcount07_tnn_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic        in_valid21 = 1'b0, in_ready21, out_valid21, out_ready21 = 1'b0, out_fire21;
    logic [20:0] in_x21 = '0, in_wp21 = '0, in_wn21 = '0;
    logic [5:0]  thr21 = '0, out_diff21;
    logic [6:0]  core_in21;
    logic [2:0]  core_cnt21;

    logic        in_valid10 = 1'b0, in_ready10, out_valid10, out_ready10 = 1'b0, out_fire10;
    logic [9:0]  in_x10 = '0, in_wp10 = '0, in_wn10 = '0;
    logic [4:0]  thr10 = '0, out_diff10;
    logic [6:0]  core_in10;
    logic [2:0]  core_cnt10;

    int approx_mode = 0;

    always_comb begin
        core_cnt21 = 3'($countones(core_in21));
        if (approx_mode == 1) core_cnt21 = 3'd7;
        if (approx_mode == 2) core_cnt21 = (core_in21 != 7'd0) ? 3'd7 : 3'd0;
    end
    assign core_cnt10 = 3'($countones(core_in10));

    popcount07_tnn_seq #(.WIDTH(21)) dut21 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid21), .in_ready(in_ready21),
        .in_x(in_x21), .in_wp(in_wp21), .in_wn(in_wn21), .thr(thr21),
        .core_in(core_in21), .core_cnt(core_cnt21), .out_valid(out_valid21),
        .out_ready(out_ready21), .out_diff(out_diff21), .out_fire(out_fire21)
    );

    popcount07_tnn_seq #(.WIDTH(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10),
        .in_x(in_x10), .in_wp(in_wp10), .in_wn(in_wn10), .thr(thr10),
        .core_in(core_in10), .core_cnt(core_cnt10), .out_valid(out_valid10),
        .out_ready(out_ready10), .out_diff(out_diff10), .out_fire(out_fire10)
    );

    typedef struct { int diff; int fire; } exp_t;
    exp_t sb[$];
    logic [6:0] seq21[$];
    logic [6:0] seq10[$];
    int npass = 0;
    int ntotal = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int core_model(input logic [6:0] c, input int mode);
        if (mode == 1) return 7;
        if (mode == 2) return (c != 7'd0) ? 7 : 0;
        return $countones(c);
    endfunction

    function automatic int model_diff(input logic [20:0] x, input logic [20:0] wp,
                                      input logic [20:0] wn, input int mode);
        logic [20:0] tp, tn;
        int p, n;
        tp = x & wp;
        tn = x & wn;
        p = 0;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            p += core_model(tp[7*k +: 7], mode);
            n += core_model(tn[7*k +: 7], mode);
        end
        return p - n;
    endfunction

    task automatic run21(input logic [20:0] x, input logic [20:0] wp, input logic [20:0] wn,
                         input int t, output int lat);
        exp_t e;
        check("accept_in_ready", int'(in_ready21), 1);
        in_x21 = x; in_wp21 = wp; in_wn21 = wn; thr21 = t[5:0]; in_valid21 = 1'b1;
        e.diff = model_diff(x, wp, wn, approx_mode);
        e.fire = (e.diff >= t) ? 1 : 0;
        sb.push_back(e);
        tick();
        in_valid21 = 1'b0;
        lat = 1;
        seq21.delete();
        while (!out_valid21 && lat < 40) begin
            seq21.push_back(core_in21);
            tick();
            lat++;
        end
        check("out_valid_seen", int'(out_valid21), 1);
    endtask

    task automatic take21(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_diff"}, int'($signed(out_diff21)), e.diff);
            check({tag, "_fire"}, int'(out_fire21), e.fire);
        end
        out_ready21 = 1'b1;
        tick();
        out_ready21 = 1'b0;
        check({tag, "_idle_ready"}, int'(in_ready21), 1);
        check({tag, "_valid_drop"}, int'(out_valid21), 0);
    endtask

    initial begin
        int lat;
        logic [6:0] exp_seq2 [6];
        logic [6:0] exp_seq3 [4];
        exp_seq2 = '{7'h7F, 7'h00, 7'h00, 7'h03, 7'h00, 7'h00};
        exp_seq3 = '{7'h00, 7'h00, 7'h7F, 7'h07};

        // reset held two cycles
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_in_ready", int'(in_ready21), 1);
        check("rst_out_valid", int'(out_valid21), 0);
        check("rst_out_diff", int'(out_diff21), 0);
        check("rst_out_fire", int'(out_fire21), 0);
        check("rst_core_in", int'(core_in21), 0);
        rst_n = 1'b1;
        tick();

        // basic neuron
        run21(21'h1FFFFF, 21'h00007F, 21'h000003, 4, lat);
        check("basic_latency", lat, 7);
        check("basic_seq_len", seq21.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < seq21.size()) check($sformatf("basic_core_in%0d", i), int'(seq21[i]), int'(exp_seq2[i]));
        end
        check("done_core_in", int'(core_in21), 0);
        take21("basic");

        // negative result with zero padding on a 10-bit neuron
        check("w10_accept_ready", int'(in_ready10), 1);
        in_x10 = 10'h3FF; in_wp10 = 10'h000; in_wn10 = 10'h3FF; thr10 = 5'd0; in_valid10 = 1'b1;
        tick();
        in_valid10 = 1'b0;
        lat = 1;
        while (!out_valid10 && lat < 40) begin
            seq10.push_back(core_in10);
            tick();
            lat++;
        end
        check("w10_latency", lat, 5);
        check("w10_seq_len", seq10.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < seq10.size()) check($sformatf("w10_core_in%0d", i), int'(seq10[i]), int'(exp_seq3[i]));
        end
        check("w10_diff", int'($signed(out_diff10)), -10);
        check("w10_fire", int'(out_fire10), 0);
        out_ready10 = 1'b1;
        tick();
        out_ready10 = 1'b0;
        check("w10_idle", int'(in_ready10), 1);

        // backpressure with a spurious second operand set
        run21(21'h0F0F0F, 21'h1FFFFF, 21'h00FF00, 10, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid21 = 1'b1; in_x21 = 21'h1FFFFF; in_wp21 = 21'h1FFFFF; in_wn21 = 21'h0; thr21 = 6'd0;
            check($sformatf("bp_diff%0d", i), int'($signed(out_diff21)), 8);
            check($sformatf("bp_fire%0d", i), int'(out_fire21), 0);
            check($sformatf("bp_in_ready%0d", i), int'(in_ready21), 0);
            check($sformatf("bp_valid%0d", i), int'(out_valid21), 1);
            tick();
        end
        in_valid21 = 1'b0;
        take21("bp");
        check("bp_retained_diff", int'($signed(out_diff21)), 8);
        tick();
        check("bp_no_restart", int'(in_ready21), 1);

        // reset during the second negative chunk
        in_x21 = 21'h1FFFFF; in_wp21 = 21'h1FFFFF; in_wn21 = 21'h1FFFFF; thr21 = 6'd0; in_valid21 = 1'b1;
        tick();
        in_valid21 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("midrst_in_neg", int'(core_in21), 7'h7F);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_in_ready", int'(in_ready21), 1);
        check("midrst_out_valid", int'(out_valid21), 0);
        check("midrst_core_in", int'(core_in21), 0);
        check("midrst_out_diff", int'(out_diff21), 0);
        run21(21'h1FFFFF, 21'h1FFFFF, 21'h000000, 21, lat);
        take21("after_rst");

        // approximate cores
        approx_mode = 1;
        run21(21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF, 0, lat);
        take21("approx_both");
        approx_mode = 2;
        run21(21'h040201, 21'h1FFFFF, 21'h000000, -5, lat);
        take21("approx_pos");
        approx_mode = 0;

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
